cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss-handling FSM for the set-associative cache. Sits between the tag-lookup stage, the set-dueling
//  replacement policy and the memory port. Reports every lookup outcome to the policy (hit/miss/index/way)
//  and consumes its evict_way. On a miss it writes back a dirty victim, fetches the line and commits tag+data.
// PARAMETERS
//  ADDR_WIDTH   32  byte address width
//  DATA_WIDTH   32  word width
//  INDEX_WIDTH  5   set index bits (DEPTH = 2**INDEX_WIDTH)
//  WAY_BITS     2   encoded way width (ASSOCIATIVITY = 2**WAY_BITS)
//  LINE_WORDS   4   words per line (power of 2); OFF_W = $clog2(LINE_WORDS)+2, TAG_W = ADDR_WIDTH-INDEX_WIDTH-OFF_W
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous reset, active low
//  lu_valid       in   1           tag lookup result valid this cycle
//  lu_addr        in   ADDR_WIDTH  looked-up address
//  lu_hit         in   1           lookup hit
//  lu_hit_way     in   WAY_BITS    hitting way
//  rp_valid/rp_hit/rp_miss out 1   replacement-policy event strobe / hit / miss
//  rp_index       out  INDEX_WIDTH set index to policy
//  rp_hit_way     out  WAY_BITS    hit way to policy
//  rp_halt        out  1           policy halt; =busy
//  rp_evict_way   in   WAY_BITS    policy victim choice (combinational, same cycle as rp_valid)
//  vic_valid/vic_dirty in 1        victim metadata at {idx_q,way_q}
//  vic_tag        in   TAG_W       victim tag
//  vic_rd_word    out  log2(LINE_WORDS) victim data word select; vic_rd_data in DATA_WIDTH (comb read)
//  mem_req_valid  out 1; mem_req_ready in 1; mem_req_we out 1; mem_req_addr out ADDR_WIDTH; mem_req_wdata out DATA_WIDTH
//  mem_rsp_valid  in 1; mem_rsp_data in DATA_WIDTH   read data, one word per valid, in order
//  fill_we out 1; fill_way out WAY_BITS; fill_index out INDEX_WIDTH; fill_word out log2(LINE_WORDS); fill_data out DATA_WIDTH
//  tag_we out 1; tag_wdata out TAG_W   commit: tag written, valid=1, dirty=0 at {fill_index,fill_way}
//  busy           out 1           state != IDLE; core stalls
//  done           out 1           one-cycle pulse on commit
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counters=0, all outputs 0. No partial tag commit ever occurs.
//  - idx = lu_addr[OFF_W+INDEX_WIDTH-1:OFF_W]. rp_* are combinational from IDLE-state inputs.
//  - IDLE, lu_valid&lu_hit: rp_valid=rp_hit=1, rp_index=idx, rp_hit_way=lu_hit_way; stay IDLE.
//  - IDLE, lu_valid&!lu_hit: rp_valid=rp_miss=1; latch addr_q, idx_q, way_q<=rp_evict_way; ->VICTIM.
//  - lu_valid when busy: ignored, no rp strobe. rp_valid is high at most one cycle per access.
//  - VICTIM (1 cycle): vic_valid&vic_dirty -> WB, else -> FILL_REQ.
//  - WB: cnt 0..LINE_WORDS-1; mem_req_valid=1, we=1, addr={vic_tag,idx_q,cnt,2'b00}, wdata=vic_rd_data,
//    vic_rd_word=cnt. Request held stable until mem_req_ready; cnt++ per accepted beat; last -> FILL_REQ.
//  - FILL_REQ: mem_req_valid=1, we=0, addr={addr_q tag,idx_q,OFF_W'0}; accepted on ready -> FILL_RSP, cnt=0.
//  - FILL_RSP: each mem_rsp_valid: fill_we=1, fill_way=way_q, fill_index=idx_q, fill_word=cnt, fill_data=mem_rsp_data;
//    cnt++; last word -> COMMIT. Counter wraps to 0 after LINE_WORDS-1.
//  - COMMIT (1 cycle): tag_we=1, tag_wdata=addr_q tag, done=1 -> IDLE. busy drops next cycle.
//  - mem_rsp_valid outside FILL_RSP: ignored. mem_req_ready while mem_req_valid=0: ignored.
//  - Min latency, clean miss, zero-wait memory: VICTIM, FILL_REQ, LINE_WORDS rsp cycles, COMMIT.
// TESTING
//  1. Hit: lu_valid=1,lu_hit=1,lu_hit_way=2,lu_addr=0x30 -> same cycle rp_valid=rp_hit=1,rp_index=3,rp_hit_way=2; no mem_req; busy=0.
//  2. Clean miss: lu_addr=0x1230, rp_evict_way=1, vic_valid=1,vic_dirty=0 -> one read, addr 0x1230; rsp D0..D3 with gaps
//     -> fill_we x4 words 0..3 way 1 index 3; tag_we tag 0x9; done 1 cycle; busy 0 after.
//  3. Dirty miss: vic_dirty=1,vic_tag=0x3A, ready low 3 cycles on beat 2 -> writes 0x7430,0x7434,0x7438,0x743C,
//     addr/wdata stable while stalled; then read as in 2.
//  4. FILL_REQ with mem_req_ready low 5 cycles -> request held, no fill_we until accepted.
//  5. rst_n low in FILL_RSP after 2 words -> all outputs 0 immediately; later rsp ignored; no tag_we; next miss completes.
//  6. lu_valid pulses while busy and mem_rsp_valid in IDLE -> no rp strobe, no fill_we, state unchanged.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller for the set-associative cache. Reports every lookup
// outcome to the replacement policy, then on a miss writes back a dirty victim,
// fetches the missing line word by word and commits the new tag.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned WAY_BITS    = 2,
  parameter int unsigned LINE_WORDS  = 4,
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS),
  localparam int unsigned OFF_W      = WORD_W + 2,
  localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_WIDTH - OFF_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // tag lookup result
  input  logic                   lu_valid_i,
  input  logic [ADDR_WIDTH-1:0]  lu_addr_i,
  input  logic                   lu_hit_i,
  input  logic [WAY_BITS-1:0]    lu_hit_way_i,
  // replacement policy
  output logic                   rp_valid_o,
  output logic                   rp_hit_o,
  output logic                   rp_miss_o,
  output logic [INDEX_WIDTH-1:0] rp_index_o,
  output logic [WAY_BITS-1:0]    rp_hit_way_o,
  output logic                   rp_halt_o,
  input  logic [WAY_BITS-1:0]    rp_evict_way_i,
  // victim line metadata and data
  input  logic                   vic_valid_i,
  input  logic                   vic_dirty_i,
  input  logic [TAG_W-1:0]       vic_tag_i,
  output logic [WORD_W-1:0]      vic_rd_word_o,
  input  logic [DATA_WIDTH-1:0]  vic_rd_data_i,
  // memory port
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]  mem_rsp_data_i,
  // data array fill
  output logic                   fill_we_o,
  output logic [WAY_BITS-1:0]    fill_way_o,
  output logic [INDEX_WIDTH-1:0] fill_index_o,
  output logic [WORD_W-1:0]      fill_word_o,
  output logic [DATA_WIDTH-1:0]  fill_data_o,
  // tag array commit
  output logic                   tag_we_o,
  output logic [TAG_W-1:0]       tag_wdata_o,
  // status
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StVictim,
    StWb,
    StFillReq,
    StFillRsp,
    StCommit
  } state_e;

  localparam logic [WORD_W-1:0] CntLast = WORD_W'(LINE_WORDS - 1);

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [WAY_BITS-1:0]    way_q, way_d;
  logic [WORD_W-1:0]      cnt_q, cnt_d;

  logic [INDEX_WIDTH-1:0] lu_idx;
  logic [TAG_W-1:0]       lu_tag;
  logic                   unused_addr;

  assign lu_idx      = lu_addr_i[OFF_W +: INDEX_WIDTH];
  assign lu_tag      = lu_addr_i[ADDR_WIDTH-1 -: TAG_W];
  // Byte/word offset of the missing address is irrelevant: whole lines move.
  assign unused_addr = ^lu_addr_i[OFF_W-1:0];

  // State and miss context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and miss-context update.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lu_valid_i && !lu_hit_i) begin
          tag_d   = lu_tag;
          idx_d   = lu_idx;
          way_d   = rp_evict_way_i;
          cnt_d   = '0;
          state_d = StVictim;
        end
      end
      StVictim: begin
        cnt_d   = '0;
        state_d = (vic_valid_i && vic_dirty_i) ? StWb : StFillReq;
      end
      StWb: begin
        if (mem_req_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StFillReq;
          end
        end
      end
      StFillReq: begin
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = StFillRsp;
        end
      end
      StFillRsp: begin
        if (mem_rsp_valid_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StCommit;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs; every field is forced to zero when its strobe is inactive.
  always_comb begin
    rp_valid_o      = 1'b0;
    rp_hit_o        = 1'b0;
    rp_miss_o       = 1'b0;
    rp_index_o      = '0;
    rp_hit_way_o    = '0;
    vic_rd_word_o   = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    fill_we_o       = 1'b0;
    fill_way_o      = '0;
    fill_index_o    = '0;
    fill_word_o     = '0;
    fill_data_o     = '0;
    tag_we_o        = 1'b0;
    tag_wdata_o     = '0;
    done_o          = 1'b0;
    busy_o          = (state_q != StIdle);
    rp_halt_o       = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (lu_valid_i) begin
          rp_valid_o   = 1'b1;
          rp_hit_o     = lu_hit_i;
          rp_miss_o    = !lu_hit_i;
          rp_index_o   = lu_idx;
          rp_hit_way_o = lu_hit_i ? lu_hit_way_i : '0;
        end
      end
      StWb: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {vic_tag_i, idx_q, cnt_q, 2'b00};
        mem_req_wdata_o = vic_rd_data_i;
        vic_rd_word_o   = cnt_q;
      end
      StFillReq: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {tag_q, idx_q, {OFF_W{1'b0}}};
      end
      StFillRsp: begin
        if (mem_rsp_valid_i) begin
          fill_we_o    = 1'b1;
          fill_way_o   = way_q;
          fill_index_o = idx_q;
          fill_word_o  = cnt_q;
          fill_data_o  = mem_rsp_data_i;
        end
      end
      StCommit: begin
        tag_we_o    = 1'b1;
        tag_wdata_o = tag_q;
        done_o      = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected policy
// events, memory requests, fills and tag commits; a negedge monitor pops them.
module tb_cache_refill_ctrl;

  localparam int TAG_W = 23;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lu_valid = 1'b0;
  logic [31:0] lu_addr = '0;
  logic        lu_hit = 1'b0;
  logic [1:0]  lu_hit_way = '0;
  logic        rp_valid, rp_hit, rp_miss, rp_halt;
  logic [4:0]  rp_index;
  logic [1:0]  rp_hit_way;
  logic [1:0]  evict_way = '0;
  logic        vic_valid = 1'b0, vic_dirty = 1'b0;
  logic [TAG_W-1:0] vic_tag = '0;
  logic [1:0]  vic_rd_word;
  logic [31:0] vic_rd_data;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        fill_we;
  logic [1:0]  fill_way, fill_word;
  logic [4:0]  fill_index;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [TAG_W-1:0] tag_wdata;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  logic [8:0]       rp_q[$];    // {hit, miss, index, hit_way}
  logic [64:0]      mem_q[$];   // {we, addr, wdata}
  logic [40:0]      fill_q[$];  // {way, index, word, data}
  logic [TAG_W-1:0] tag_q[$];

  // Victim data array model: word w of the victim line reads as C0DE_000w.
  assign vic_rd_data = 32'hC0DE_0000 + {30'd0, vic_rd_word};

  always #5 clk_i = ~clk_i;

  cache_refill_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .lu_valid_i      (lu_valid),
    .lu_addr_i       (lu_addr),
    .lu_hit_i        (lu_hit),
    .lu_hit_way_i    (lu_hit_way),
    .rp_valid_o      (rp_valid),
    .rp_hit_o        (rp_hit),
    .rp_miss_o       (rp_miss),
    .rp_index_o      (rp_index),
    .rp_hit_way_o    (rp_hit_way),
    .rp_halt_o       (rp_halt),
    .rp_evict_way_i  (evict_way),
    .vic_valid_i     (vic_valid),
    .vic_dirty_i     (vic_dirty),
    .vic_tag_i       (vic_tag),
    .vic_rd_word_o   (vic_rd_word),
    .vic_rd_data_i   (vic_rd_data),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_we_o    (mem_req_we),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data),
    .fill_we_o       (fill_we),
    .fill_way_o      (fill_way),
    .fill_index_o    (fill_index),
    .fill_word_o     (fill_word),
    .fill_data_o     (fill_data),
    .tag_we_o        (tag_we),
    .tag_wdata_o     (tag_wdata),
    .busy_o          (busy),
    .done_o          (done)
  );

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rsp_word(input logic [31:0] addr, input int w);
    return {addr[15:0], 16'h0D00 + 16'(w)};
  endfunction

  task automatic check_outs_zero(input string name);
    logic [127:0] act;
    act = {rp_valid, rp_halt, vic_rd_word, mem_req_valid, mem_req_we, mem_req_addr,
           mem_req_wdata, fill_we, fill_data, tag_we, tag_wdata, busy, done};
    check(act == '0 && rp_index == '0 && fill_index == '0 && fill_way == '0 &&
          fill_word == '0 && rp_hit == 1'b0 && rp_miss == 1'b0, name, act, 128'd0);
  endtask

  // Monitor: pop and compare whenever the DUT presents an event.
  initial begin
    logic [8:0]  erp;
    logic [64:0] emem;
    logic [40:0] efill;
    logic [TAG_W-1:0] etag;
    forever begin
      @(negedge clk_i);
      if (rp_valid) begin
        if (rp_q.size() == 0) check(1'b0, "rp_unexpected", {rp_hit, rp_miss, rp_index}, 0);
        else begin
          erp = rp_q.pop_front();
          check({rp_hit, rp_miss, rp_index, rp_hit ? rp_hit_way : 2'b00} == erp, "rp_event",
                {rp_hit, rp_miss, rp_index, rp_hit_way}, erp);
        end
      end
      if (mem_req_valid && mem_q.size() == 0)
        check(1'b0, "mem_unexpected", {mem_req_we, mem_req_addr}, 0);
      else if (mem_req_valid && mem_req_ready) begin
        emem = mem_q.pop_front();
        check({mem_req_we, mem_req_addr, mem_req_we ? mem_req_wdata : 32'd0} == emem, "mem_req",
              {mem_req_we, mem_req_addr, mem_req_wdata}, emem);
      end
      if (fill_we) begin
        if (fill_q.size() == 0) check(1'b0, "fill_unexpected", {fill_word, fill_data}, 0);
        else begin
          efill = fill_q.pop_front();
          check({fill_way, fill_index, fill_word, fill_data} == efill, "fill",
                {fill_way, fill_index, fill_word, fill_data}, efill);
        end
      end
      if (tag_we) begin
        if (tag_q.size() == 0) check(1'b0, "tag_unexpected", tag_wdata, 0);
        else begin
          etag = tag_q.pop_front();
          check({done, tag_wdata} == {1'b1, etag}, "tag_commit", {done, tag_wdata}, {1'b1, etag});
        end
      end else if (done) begin
        check(1'b0, "done_without_tag_we", done, 0);
      end
    end
  end

  // Issue a miss and act as the memory. Stalls beat st_beat of the writeback
  // for st_len cycles, holds off the read for rd_st cycles, gaps responses by
  // gap cycles, and optionally resets after abort response words.
  task automatic run_miss(input logic [31:0] addr, input logic [1:0] ew, input logic vvalid,
                          input logic vdirty, input logic [TAG_W-1:0] vtag, input int st_beat,
                          input int st_len, input int rd_st, input int gap, input int abort,
                          input bit noise, output int done_cyc);
    logic [4:0]       idx;
    logic [TAG_W-1:0] tag;
    int wr_beat, st_left, rd_left, rsp_idx, gap_left, n_fill;
    bit rsp_on, aborted, have_prev, finished, saw_done;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    idx = addr[8:4];
    tag = addr[31:9];
    evict_way = ew;
    vic_valid = vvalid;
    vic_dirty = vdirty;
    vic_tag = vtag;
    rp_q.push_back({1'b0, 1'b1, idx, 2'b00});
    if (vvalid && vdirty)
      for (int w = 0; w < 4; w++)
        mem_q.push_back({1'b1, vtag, idx, 2'(w), 2'b00, 32'hC0DE_0000 + 32'(w)});
    mem_q.push_back({1'b0, tag, idx, 4'h0, 32'd0});
    n_fill = (abort < 0) ? 4 : abort;
    for (int w = 0; w < n_fill; w++) fill_q.push_back({ew, idx, 2'(w), rsp_word(addr, w)});
    if (abort < 0) tag_q.push_back(tag);

    lu_valid = 1'b1;
    lu_hit = 1'b0;
    lu_addr = addr;
    wr_beat = 0; st_left = st_len; rd_left = rd_st; rsp_idx = 0; gap_left = gap;
    rsp_on = 0; aborted = 0; have_prev = 0; finished = 0; saw_done = 0; done_cyc = -1;
    prev_we = 0; prev_addr = '0; prev_wdata = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk_i);
      #1;
      if (aborted && !rst_ni) rst_ni = 1'b1;
      lu_valid = noise && (cyc % 2 == 1);
      lu_hit = 1'b0;
      lu_addr = 32'hFFFF_FFF0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
      if (saw_done) begin
        check(!busy && !done && !tag_we, "idle_after_done", {busy, done, tag_we}, 0);
        finished = 1;
        break;
      end
      if (done) begin
        done_cyc = cyc;
        saw_done = 1;
        check(busy, "busy_in_commit", busy, 1);
      end
      if (have_prev)
        check(mem_req_valid && mem_req_we == prev_we && mem_req_addr == prev_addr &&
              (!prev_we || mem_req_wdata == prev_wdata), "req_stable_stall",
              {mem_req_valid, mem_req_addr, mem_req_wdata}, {1'b1, prev_addr, prev_wdata});
      have_prev = 0;
      if (abort >= 0 && !aborted && rsp_idx == abort) begin
        rst_ni = 1'b0;
        #1;
        check_outs_zero("outs_zero_in_reset");
        aborted = 1;
        continue;
      end
      if (aborted && rsp_idx >= 4) begin
        check(!busy && !fill_we && !tag_we, "idle_after_abort", {busy, fill_we, tag_we}, 0);
        finished = 1;
        break;
      end
      if (mem_req_valid) begin
        if (mem_req_we) begin
          if (wr_beat == st_beat && st_left > 0) st_left--;
          else begin
            mem_req_ready = 1'b1;
            wr_beat++;
          end
        end else begin
          if (rd_left > 0) begin
            check(!fill_we, "no_fill_before_read", fill_we, 0);
            rd_left--;
          end else begin
            mem_req_ready = 1'b1;
            rsp_on = 1;
          end
        end
        if (!mem_req_ready) begin
          have_prev = 1;
          prev_we = mem_req_we;
          prev_addr = mem_req_addr;
          prev_wdata = mem_req_wdata;
        end
      end else if (rsp_on && rsp_idx < 4) begin
        if (gap_left > 0) gap_left--;
        else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data = rsp_word(addr, rsp_idx);
          rsp_idx++;
          gap_left = gap;
        end
      end
    end
    lu_valid = 1'b0;
    check(finished, "miss_timeout", finished, 1);
  endtask

  initial begin
    int dc;
    #1;
    check_outs_zero("reset_outputs");
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check(!busy && !rp_halt, "idle_after_reset", {busy, rp_halt}, 0);

    // Hit: index 3, way 2, no memory traffic, never busy.
    @(posedge clk_i);
    #1;
    rp_q.push_back({1'b1, 1'b0, 5'd3, 2'd2});
    lu_valid = 1'b1; lu_hit = 1'b1; lu_hit_way = 2'd2; lu_addr = 32'h30;
    #1;
    check(!busy && !mem_req_valid, "hit_no_busy", {busy, mem_req_valid}, 0);
    @(posedge clk_i);
    #1;
    lu_valid = 1'b0; lu_hit = 1'b0;
    check(!busy && !mem_req_valid, "hit_stays_idle", {busy, mem_req_valid}, 0);

    // Clean miss with gaps between response words.
    run_miss(32'h1230, 2'd1, 1'b1, 1'b0, 23'h0, 0, 0, 0, 2, -1, 1'b0, dc);
    // Dirty miss: writeback beat 2 stalled 3 cycles, then the read.
    run_miss(32'h1230, 2'd3, 1'b1, 1'b1, 23'h3A, 2, 3, 0, 1, -1, 1'b0, dc);
    // Invalid-but-dirty victim needs no writeback; read stalled 5 cycles,
    // lookups arriving while busy must be ignored.
    run_miss(32'h5670, 2'd2, 1'b0, 1'b1, 23'h11, 0, 0, 5, 0, -1, 1'b1, dc);
    // Reset after two fill words, then a zero-wait miss for minimum latency.
    run_miss(32'h2340, 2'd0, 1'b1, 1'b0, 23'h0, 0, 0, 0, 0, 2, 1'b0, dc);
    run_miss(32'h1230, 2'd2, 1'b1, 1'b0, 23'h0, 0, 0, 0, 0, -1, 1'b0, dc);
    check(dc == 6, "min_latency_done_cycle", dc, 6);

    // Responses and ready while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hBAD0_0000 + 32'(i);
      mem_req_ready = 1'b1;
      #1;
      check(!busy && !fill_we, "idle_rsp_ignored", {busy, fill_we}, 0);
      @(posedge clk_i);
      #1;
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    check(!busy, "idle_after_stray_rsp", busy, 0);
    repeat (2) @(posedge clk_i);
    #1;

    check(rp_q.size() == 0, "rp_queue_drained", rp_q.size(), 0);
    check(mem_q.size() == 0, "mem_queue_drained", mem_q.size(), 0);
    check(fill_q.size() == 0, "fill_queue_drained", fill_q.size(), 0);
    check(tag_q.size() == 0, "tag_queue_drained", tag_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
